// File: rtl/ysyx_22041412_axi_rd_arbiter.sv
// rtl/ysyx_22041412_axi_rd_arbiter.sv - round-robin AXI read channel arbiter for Icache/Dcache refills
module ysyx_22041412_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [7:0]        i_req_len,
    output logic              i_resp_valid,
    output logic              i_resp_last,
    output logic [DATA_W-1:0] i_resp_data,

    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [7:0]        d_req_len,
    output logic              d_resp_valid,
    output logic              d_resp_last,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [7:0]        mem_arlen,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rlast,
    output logic              mem_rready,

    output logic [CNT_W-1:0]  grant_i_cnt,
    output logic [CNT_W-1:0]  grant_d_cnt,
    output logic [CNT_W-1:0]  contend_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Port identity: 0 = Icache, 1 = Dcache
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              abort_q, abort_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [CNT_W-1:0]  grant_i_q, grant_i_d;
    logic [CNT_W-1:0]  grant_d_q, grant_d_d;
    logic [CNT_W-1:0]  contend_q, contend_d;

    logic              owner_req;
    logic              other_req;
    logic              pick;
    logic              in_data;
    logic              own_i;
    logic              own_d;

    assign owner_req = (owner_q == OWN_D) ? d_req_valid : i_req_valid;
    assign other_req = (owner_q == OWN_D) ? i_req_valid : d_req_valid;

    // On a tie the port that did not win last time goes first
    assign pick = (i_req_valid && d_req_valid) ? ~last_grant_q : d_req_valid;

    // State register and all bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            abort_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            grant_i_q    <= '0;
            grant_d_q    <= '0;
            contend_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            abort_q      <= abort_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            grant_i_q    <= grant_i_d;
            grant_d_q    <= grant_d_d;
            contend_q    <= contend_d;
        end
    end

    // Next-state: grant in IDLE, AR handshake in ADDR, drain the burst in DATA
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        abort_d      = abort_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        grant_i_d    = grant_i_q;
        grant_d_d    = grant_d_q;
        contend_d    = contend_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    owner_d   = pick;
                    araddr_d  = (pick == OWN_D) ? d_req_addr : i_req_addr;
                    arlen_d   = (pick == OWN_D) ? d_req_len  : i_req_len;
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!owner_req) begin
                    abort_d = 1'b1;
                end
                if (mem_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (!owner_req) begin
                    abort_d = 1'b1;
                end
                if (mem_rvalid && mem_rlast) begin
                    state_d      = S_IDLE;
                    last_grant_d = owner_q;
                    abort_d      = 1'b0;
                    if (owner_q == OWN_D) begin
                        grant_d_d = grant_d_q + 1'b1;
                    end else begin
                        grant_i_d = grant_i_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && other_req) begin
            contend_d = contend_q + 1'b1;
        end
    end

    assign in_data = (state_q == S_DATA);
    assign own_i   = in_data && (owner_q == OWN_I);
    assign own_d   = in_data && (owner_q == OWN_D);

    assign mem_rready   = in_data;
    assign mem_arvalid  = arvalid_q;
    assign mem_araddr   = araddr_q;
    assign mem_arlen    = arlen_q;

    // Beats reach only the owner, and only while its fetch is still wanted
    assign i_resp_valid = own_i && mem_rvalid && !abort_q;
    assign i_resp_last  = i_resp_valid && mem_rlast;
    assign i_resp_data  = own_i ? mem_rdata : '0;
    assign d_resp_valid = own_d && mem_rvalid && !abort_q;
    assign d_resp_last  = d_resp_valid && mem_rlast;
    assign d_resp_data  = own_d ? mem_rdata : '0;

    assign grant_i_cnt  = grant_i_q;
    assign grant_d_cnt  = grant_d_q;
    assign contend_cnt  = contend_q;

endmodule

// File: tb/tb_ysyx_22041412_axi_rd_arbiter.sv
// tb/tb_ysyx_22041412_axi_rd_arbiter.sv - directed self-checking bench for the AXI read arbiter
module tb_ysyx_22041412_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic        i_resp_valid;
    logic        i_resp_last;
    logic [63:0] i_resp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic [7:0]  d_req_len;
    logic        d_resp_valid;
    logic        d_resp_last;
    logic [63:0] d_resp_data;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_rready;
    logic [63:0] grant_i_cnt;
    logic [63:0] grant_d_cnt;
    logic [63:0] contend_cnt;

    int checks;
    int failures;

    ysyx_22041412_axi_rd_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_len    (i_req_len),
        .i_resp_valid (i_resp_valid),
        .i_resp_last  (i_resp_last),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_len    (d_req_len),
        .d_resp_valid (d_resp_valid),
        .d_resp_last  (d_resp_last),
        .d_resp_data  (d_resp_data),
        .mem_arvalid  (mem_arvalid),
        .mem_araddr   (mem_araddr),
        .mem_arlen    (mem_arlen),
        .mem_arready  (mem_arready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rlast    (mem_rlast),
        .mem_rready   (mem_rready),
        .grant_i_cnt  (grant_i_cnt),
        .grant_d_cnt  (grant_d_cnt),
        .contend_cnt  (contend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1ns later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic beat(input logic [63:0] data, input logic last);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        mem_rlast  = last;
    endtask

    task automatic no_beat();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rlast  = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_len   = '0;
        d_req_valid = 1'b0;
        d_req_addr  = '0;
        d_req_len   = '0;
        mem_arready = 1'b0;
        no_beat();

        next_cycle();
        next_cycle();
        #1;
        check_eq("rst_arvalid", {63'd0, mem_arvalid}, 64'd0);
        check_eq("rst_araddr", {32'd0, mem_araddr}, 64'd0);
        check_eq("rst_rready", {63'd0, mem_rready}, 64'd0);
        check_eq("rst_grant_i", grant_i_cnt, 64'd0);
        check_eq("rst_contend", contend_cnt, 64'd0);
        rst = 1'b1;

        // Single Icache request, zero-wait AR, two beats
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0010; i_req_len = 8'd1;
        #1 check_eq("t1_idle_arvalid", {63'd0, mem_arvalid}, 64'd0);
        next_cycle();
        mem_arready = 1'b1;
        #1;
        check_eq("t1_arvalid", {63'd0, mem_arvalid}, 64'd1);
        check_eq("t1_araddr", {32'd0, mem_araddr}, 64'h8000_0010);
        check_eq("t1_arlen", {56'd0, mem_arlen}, 64'd1);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'hA, 1'b0);
        #1;
        check_eq("t1_arvalid_once", {63'd0, mem_arvalid}, 64'd0);
        check_eq("t1_rready", {63'd0, mem_rready}, 64'd1);
        check_eq("t1_b0_valid", {63'd0, i_resp_valid}, 64'd1);
        check_eq("t1_b0_data", i_resp_data, 64'hA);
        check_eq("t1_b0_last", {63'd0, i_resp_last}, 64'd0);
        check_eq("t1_d_valid", {63'd0, d_resp_valid}, 64'd0);
        next_cycle();
        beat(64'hB, 1'b1);
        #1;
        check_eq("t1_b1_valid", {63'd0, i_resp_valid}, 64'd1);
        check_eq("t1_b1_data", i_resp_data, 64'hB);
        check_eq("t1_b1_last", {63'd0, i_resp_last}, 64'd1);
        check_eq("t1_b1_d_data", d_resp_data, 64'd0);
        next_cycle();
        i_req_valid = 1'b0;
        no_beat();
        #1;
        check_eq("t1_grant_i", grant_i_cnt, 64'd1);
        check_eq("t1_grant_d", grant_d_cnt, 64'd0);
        check_eq("t1_done_arvalid", {63'd0, mem_arvalid}, 64'd0);

        // Tie: D first, I waits and is counted, then a second tie goes to I
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_2000; i_req_len = 8'd0;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_1000; d_req_len = 8'd0;
        next_cycle();
        mem_arready = 1'b1;
        #1 check_eq("t2_tie1_addr", {32'd0, mem_araddr}, 64'h1000);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h55, 1'b1);
        #1;
        check_eq("t2_d_valid", {63'd0, d_resp_valid}, 64'd1);
        check_eq("t2_d_last", {63'd0, d_resp_last}, 64'd1);
        check_eq("t2_d_data", d_resp_data, 64'h55);
        check_eq("t2_i_valid", {63'd0, i_resp_valid}, 64'd0);
        check_eq("t2_i_data", i_resp_data, 64'd0);
        next_cycle();
        no_beat();
        #1;
        check_eq("t2_contend_a", contend_cnt, 64'd2);
        check_eq("t2_grant_d", grant_d_cnt, 64'd1);
        check_eq("t2_idle_arvalid", {63'd0, mem_arvalid}, 64'd0);
        next_cycle();
        mem_arready = 1'b1;
        #1 check_eq("t2_tie2_addr", {32'd0, mem_araddr}, 64'h2000);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h66, 1'b1);
        #1;
        check_eq("t2_i_valid2", {63'd0, i_resp_valid}, 64'd1);
        check_eq("t2_i_data2", i_resp_data, 64'h66);
        check_eq("t2_d_valid2", {63'd0, d_resp_valid}, 64'd0);
        next_cycle();
        i_req_valid = 1'b0;
        no_beat();
        #1;
        check_eq("t2_contend_b", contend_cnt, 64'd4);
        check_eq("t2_grant_i", grant_i_cnt, 64'd2);
        next_cycle();
        mem_arready = 1'b1;
        #1 check_eq("t2_d_again_addr", {32'd0, mem_araddr}, 64'h1000);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h77, 1'b1);
        next_cycle();
        d_req_valid = 1'b0;
        no_beat();
        #1;
        check_eq("t2_grant_d2", grant_d_cnt, 64'd2);
        check_eq("t2_contend_c", contend_cnt, 64'd4);

        // AR ready delayed three cycles; stray R beats before the handshake are dropped
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0040; i_req_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            i_req_addr = 32'h1234_5670;
            i_req_len  = 8'd9;
            beat(64'hDEAD, 1'b0);
            #1;
            check_eq($sformatf("t3_arvalid_%0d", k), {63'd0, mem_arvalid}, 64'd1);
            check_eq($sformatf("t3_araddr_%0d", k), {32'd0, mem_araddr}, 64'h8000_0040);
            check_eq($sformatf("t3_arlen_%0d", k), {56'd0, mem_arlen}, 64'd0);
            check_eq($sformatf("t3_no_fwd_%0d", k), {63'd0, i_resp_valid}, 64'd0);
        end
        next_cycle();
        no_beat();
        mem_arready = 1'b1;
        #1;
        check_eq("t3_arvalid_3", {63'd0, mem_arvalid}, 64'd1);
        check_eq("t3_araddr_3", {32'd0, mem_araddr}, 64'h8000_0040);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'hC, 1'b1);
        #1 check_eq("t3_beat", i_resp_data, 64'hC);
        next_cycle();
        i_req_valid = 1'b0;
        no_beat();
        #1 check_eq("t3_grant_i", grant_i_cnt, 64'd3);

        // Icache abandons its fetch after the first beat
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0100; i_req_len = 8'd1;
        next_cycle();
        mem_arready = 1'b1;
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h11, 1'b0);
        #1 check_eq("t4_b0_valid", {63'd0, i_resp_valid}, 64'd1);
        next_cycle();
        i_req_valid = 1'b0;
        no_beat();
        next_cycle();
        beat(64'h22, 1'b1);
        #1;
        check_eq("t4_b1_rready", {63'd0, mem_rready}, 64'd1);
        check_eq("t4_b1_valid", {63'd0, i_resp_valid}, 64'd0);
        check_eq("t4_b1_last", {63'd0, i_resp_last}, 64'd0);
        next_cycle();
        no_beat();
        #1;
        check_eq("t4_grant_i", grant_i_cnt, 64'd4);
        check_eq("t4_idle_rready", {63'd0, mem_rready}, 64'd0);

        // R beats while idle are ignored
        next_cycle();
        beat(64'h99, 1'b1);
        #1;
        check_eq("t6_i_valid", {63'd0, i_resp_valid}, 64'd0);
        check_eq("t6_d_valid", {63'd0, d_resp_valid}, 64'd0);
        next_cycle();
        no_beat();
        #1;
        check_eq("t6_grant_i", grant_i_cnt, 64'd4);
        check_eq("t6_grant_d", grant_d_cnt, 64'd2);
        check_eq("t6_contend", contend_cnt, 64'd4);
        check_eq("t6_arvalid", {63'd0, mem_arvalid}, 64'd0);

        // Reset in the middle of DATA with a beat pending
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0200; i_req_len = 8'd1;
        next_cycle();
        mem_arready = 1'b1;
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h33, 1'b0);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        i_req_valid = 1'b0;
        no_beat();
        #1;
        check_eq("t5_arvalid", {63'd0, mem_arvalid}, 64'd0);
        check_eq("t5_rready", {63'd0, mem_rready}, 64'd0);
        check_eq("t5_grant_i", grant_i_cnt, 64'd0);
        check_eq("t5_grant_d", grant_d_cnt, 64'd0);
        check_eq("t5_contend", contend_cnt, 64'd0);
        next_cycle();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0300; i_req_len = 8'd0;
        #1 check_eq("t5_req_arvalid0", {63'd0, mem_arvalid}, 64'd0);
        next_cycle();
        mem_arready = 1'b1;
        #1;
        check_eq("t5_req_arvalid1", {63'd0, mem_arvalid}, 64'd1);
        check_eq("t5_req_araddr", {32'd0, mem_araddr}, 64'h300);
        next_cycle();
        mem_arready = 1'b0;
        beat(64'h44, 1'b1);
        next_cycle();
        i_req_valid = 1'b0;
        no_beat();
        #1 check_eq("t5_grant_i_after", grant_i_cnt, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
